// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 encoder: loads a request vector and emits the index of each set bit, lowest first.
// Optional `cnt` popcount output is enabled by defining ENC8TO3_CNT_EN.
module enc8to3_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic [7:0] in,
    output logic       in_ready,
    output logic [2:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       zero,
    output logic       busy
`ifdef ENC8TO3_CNT_EN
    ,
    output logic [3:0] cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pend;
    logic [7:0] pend_nxt;
    logic       accept;
    logic       beat;
    logic       single;

    function automatic logic [2:0] lsb_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    assign accept = in_valid & in_ready;
    assign beat   = out_valid & out_ready;
    // Exactly one bit set: clearing the lowest set bit leaves nothing.
    assign single = (pend != 8'd0) && ((pend & (pend - 8'd1)) == 8'd0);

    // State and pending register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= 8'd0;
            zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            zero  <= accept & (in == 8'd0);
        end
    end

`ifdef ENC8TO3_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= popcount(in);
        end
    end
`endif

    // Next-state and pending update
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        case (state)
            IDLE: begin
                if (accept && (in != 8'd0)) begin
                    state_nxt = EMIT;
                    pend_nxt  = in;
                end
            end
            EMIT: begin
                if (beat) begin
                    pend_nxt = pend & (pend - 8'd1);
                    if (single) state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                pend_nxt  = 8'd0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = en & (state == IDLE);
        busy      = (state == EMIT);
        out_valid = (state == EMIT);
        out       = 3'd0;
        out_last  = 1'b0;
        if (state == EMIT) begin
            out      = lsb_idx(pend);
            out_last = single;
        end
    end

endmodule

// File: tb/tb_enc8to3_seq.sv
// Directed testbench for enc8to3_seq; cnt checks are compiled in when ENC8TO3_CNT_EN is defined.
module tb_enc8to3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic [7:0] in;
    logic       in_ready;
    logic [2:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       zero;
    logic       busy;
`ifdef ENC8TO3_CNT_EN
    logic [3:0] cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    enc8to3_seq dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in        (in),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .zero      (zero),
        .busy      (busy)
`ifdef ENC8TO3_CNT_EN
        ,
        .cnt       (cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in = 8'h00; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out !== 3'd0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: valid=%b out=%0d last=%b required 0/0/0", out_valid, out, out_last);
        end
        n_cmp++;
        if (busy !== 1'b0 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: busy=%b zero=%b required 0/0", busy, zero);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready_en0: in_ready=%b required 0", in_ready);
        end
        en = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready_en1: in_ready=%b required 1", in_ready);
        end
`ifdef ENC8TO3_CNT_EN
        n_cmp++;
        if (cnt !== 4'd0) begin
            n_err++;
            $display("FAIL reset_cnt: cnt=%0d required 0", cnt);
        end
`endif
    endtask

    task automatic test_basic();
        logic [2:0] exp_idx  [3];
        logic       exp_last [3];
        exp_idx  = '{3'd2, 3'd5, 3'd7};
        exp_last = '{1'b0, 1'b0, 1'b1};
        en = 1'b1; out_ready = 1'b1; in = 8'b1010_0100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef ENC8TO3_CNT_EN
        n_cmp++;
        if (cnt !== 4'd3) begin
            n_err++;
            $display("FAIL basic_cnt: cnt=%0d required 3", cnt);
        end
`endif
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out !== exp_idx[k] || out_last !== exp_last[k]) begin
                n_err++;
                $display("FAIL basic_beat%0d: valid=%b busy=%b out=%0d last=%b required 1/1/%0d/%b",
                         k, out_valid, busy, out, out_last, exp_idx[k], exp_last[k]);
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out !== 3'd0) begin
            n_err++;
            $display("FAIL basic_done: valid=%b busy=%b in_ready=%b out=%0d required 0/0/1/0",
                     out_valid, busy, in_ready, out);
        end
    endtask

    task automatic test_stall();
        en = 1'b1; out_ready = 1'b0; in = 8'b1000_0001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out !== 3'd0 || out_last !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold%0d: valid=%b out=%0d last=%b required 1/0/0",
                         k, out_valid, out, out_last);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 3'd0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL stall_beat0: valid=%b out=%0d last=%b required 1/0/0", out_valid, out, out_last);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 3'd7 || out_last !== 1'b1) begin
            n_err++;
            $display("FAIL stall_beat7: valid=%b out=%0d last=%b required 1/7/1", out_valid, out, out_last);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_done: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_zero();
        en = 1'b1; out_ready = 1'b1; in = 8'h00; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL zero_in_ready_pre: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (zero !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_pulse: zero=%b valid=%b in_ready=%b busy=%b required 1/0/1/0",
                     zero, out_valid, in_ready, busy);
        end
`ifdef ENC8TO3_CNT_EN
        n_cmp++;
        if (cnt !== 4'd0) begin
            n_err++;
            $display("FAIL zero_cnt: cnt=%0d required 0", cnt);
        end
`endif
        tick();
        n_cmp++;
        if (zero !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL zero_one_cycle: zero=%b valid=%b required 0/0", zero, out_valid);
        end
    endtask

    task automatic test_en_gate();
        logic [2:0] exp_idx [4];
        exp_idx = '{3'd2, 3'd3, 3'd4, 3'd5};
        en = 1'b0; out_ready = 1'b1; in = 8'h3C; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL engate_hold%0d: in_ready=%b valid=%b busy=%b required 0/0/0",
                         k, in_ready, out_valid, busy);
            end
            tick();
        end
        en = 1'b1;
        tick();
        // Drop en but keep offering a different vector: EMIT must finish and ignore it.
        en = 1'b0; in = 8'hFF;
`ifdef ENC8TO3_CNT_EN
        n_cmp++;
        if (cnt !== 4'd4) begin
            n_err++;
            $display("FAIL engate_cnt: cnt=%0d required 4", cnt);
        end
`endif
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out !== exp_idx[k] || out_last !== (k == 3)) begin
                n_err++;
                $display("FAIL engate_beat%0d: valid=%b out=%0d last=%b required 1/%0d/%b",
                         k, out_valid, out, out_last, exp_idx[k], (k == 3));
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL engate_done: valid=%b busy=%b in_ready=%b required 0/0/0",
                     out_valid, busy, in_ready);
        end
        in_valid = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset_mid();
        en = 1'b1; out_ready = 1'b1; in = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out !== k[2:0]) begin
                n_err++;
                $display("FAIL rstmid_beat%0d: valid=%b out=%0d required 1/%0d", k, out_valid, out, k);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out !== 3'd0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_flush: valid=%b busy=%b out=%0d last=%b required 0/0/0/0",
                     out_valid, busy, out, out_last);
        end
`ifdef ENC8TO3_CNT_EN
        n_cmp++;
        if (cnt !== 4'd0) begin
            n_err++;
            $display("FAIL rstmid_cnt: cnt=%0d required 0", cnt);
        end
`endif
        rst = 1'b0;
        in = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 3'd0 || out_last !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_single: valid=%b out=%0d last=%b required 1/0/1", out_valid, out, out_last);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_single_done: valid=%b busy=%b required 0/0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        en = 1'b1; out_ready = 1'b1; in = 8'hFF; in_valid = 1'b1;
        tick();
`ifdef ENC8TO3_CNT_EN
        n_cmp++;
        if (cnt !== 4'd8) begin
            n_err++;
            $display("FAIL b2b_cnt_ff: cnt=%0d required 8", cnt);
        end
`endif
        in = 8'h11;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out !== k[2:0] || out_last !== (k == 7) || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_ff_beat%0d: valid=%b out=%0d last=%b in_ready=%b required 1/%0d/%b/0",
                         k, out_valid, out, out_last, in_ready, k, (k == 7));
            end
            tick();
        end
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: in_ready=%b valid=%b required 1/0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
`ifdef ENC8TO3_CNT_EN
        n_cmp++;
        if (cnt !== 4'd2) begin
            n_err++;
            $display("FAIL b2b_cnt_11: cnt=%0d required 2", cnt);
        end
`endif
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 3'd0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_11_beat0: valid=%b out=%0d last=%b required 1/0/0", out_valid, out, out_last);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 3'd4 || out_last !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_11_beat4: valid=%b out=%0d last=%b required 1/4/1", out_valid, out, out_last);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done: valid=%b busy=%b in_ready=%b required 0/0/1", out_valid, busy, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_en_gate();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
